mvb_fifo_rd_adapter: RTL

- Read-side companion to the MVB BRAM asynchronous FIFO.
- Sits in the FIFO's read clock domain and turns the FIFO's raw read port into a standard MVB transmit interface with SRC_RDY/DST_RDY handshake.
- The raw read port has fixed read latency, is not first-word-fall-through, and carries per-region valid bits.
- Hides the read latency with a small credit-controlled output buffer, sustains one word per cycle, and drops words that have no valid region.

---
 rtl/mvb_fifo_rd_adapter_if.sv | 25 ++
 rtl/mvb_fifo_rd_adapter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mvb_fifo_rd_adapter_if.sv
// Handshake bundle between the adapter, the raw FIFO read port and the MVB sink.
// The master modport is the adapter's view; slave is the FIFO/sink environment.
interface mvb_fifo_rd_adapter_if #(
    parameter int REGIONS    = 4,
    parameter int ITEM_WIDTH = 8
);
    logic [REGIONS*ITEM_WIDTH-1:0] fifoDo;
    logic [REGIONS-1:0]            fifoDoVld;
    logic                          fifoEmpty;
    logic                          fifoRd;
    logic [REGIONS*ITEM_WIDTH-1:0] txData;
    logic [REGIONS-1:0]            txVld;
    logic                          txSrcRdy;
    logic                          txDstRdy;

    modport master (
        input  fifoDo, fifoDoVld, fifoEmpty, txDstRdy,
        output fifoRd, txData, txVld, txSrcRdy
    );

    modport slave (
        output fifoDo, fifoDoVld, fifoEmpty, txDstRdy,
        input  fifoRd, txData, txVld, txSrcRdy
    );
endinterface

// File: rtl/mvb_fifo_rd_adapter.sv
// Turns a fixed-latency, non-FWFT FIFO read port into an MVB source with SRC/DST_RDY,
// using a credit-limited circular buffer that hides the read latency and drops empty words.
module mvb_fifo_rd_adapter #(
    parameter int REGIONS      = 4,
    parameter int ITEM_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    mvb_fifo_rd_adapter_if.master  bus,
    output logic [CNT_WIDTH-1:0]   txWords_o
);

    localparam int DW    = REGIONS * ITEM_WIDTH;
    localparam int D     = READ_LATENCY + 1;
    localparam int PTR_W = $clog2(D);
    localparam int OCC_W = $clog2(D + 1);
    localparam int SUM_W = OCC_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(D - 1);

    logic [DW-1:0]           bufData_q [D];
    logic [REGIONS-1:0]      bufVld_q  [D];
    logic [PTR_W-1:0]        headPtr_q, headPtr_d;
    logic [PTR_W-1:0]        tailPtr_q, tailPtr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic [READ_LATENCY-1:0] inFlight_q, inFlight_d;
    logic [CNT_WIDTH-1:0]    txWords_q, txWords_d;

    logic [SUM_W-1:0] inFlightCnt;
    logic [SUM_W-1:0] committed;
    logic             rdReq;
    logic             retValid;
    logic             wrEn;
    logic             popEn;

    always_comb begin
        inFlightCnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inFlightCnt = inFlightCnt + SUM_W'(inFlight_q[i]);
        end
    end

    // A read is only issued when the word it returns is guaranteed a free slot,
    // counting the slot freed by a pop in this same cycle.
    assign popEn     = bus.txSrcRdy && bus.txDstRdy;
    assign committed = SUM_W'(occ_q) + inFlightCnt - SUM_W'(popEn);
    assign rdReq     = rst_ni && !bus.fifoEmpty && (committed < SUM_W'(D));
    assign bus.fifoRd = rdReq;

    assign retValid = inFlight_q[READ_LATENCY-1];
    assign wrEn     = retValid && (bus.fifoDoVld != '0);

    assign bus.txSrcRdy = (occ_q != '0);
    assign bus.txData   = bufData_q[headPtr_q];
    assign bus.txVld    = bufVld_q[headPtr_q];
    assign txWords_o    = txWords_q;

    always_comb begin
        headPtr_d  = headPtr_q;
        tailPtr_d  = tailPtr_q;
        occ_d      = occ_q;
        txWords_d  = txWords_q;
        inFlight_d = READ_LATENCY'({inFlight_q, rdReq});

        if (wrEn) begin
            tailPtr_d = (tailPtr_q == LAST_PTR) ? '0 : tailPtr_q + 1'b1;
        end
        if (popEn) begin
            headPtr_d = (headPtr_q == LAST_PTR) ? '0 : headPtr_q + 1'b1;
            txWords_d = txWords_q + 1'b1;
        end
        if (wrEn && !popEn) begin
            occ_d = occ_q + 1'b1;
        end else if (!wrEn && popEn) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            headPtr_q  <= '0;
            tailPtr_q  <= '0;
            occ_q      <= '0;
            inFlight_q <= '0;
            txWords_q  <= '0;
        end else begin
            headPtr_q  <= headPtr_d;
            tailPtr_q  <= tailPtr_d;
            occ_q      <= occ_d;
            inFlight_q <= inFlight_d;
            txWords_q  <= txWords_d;
        end
    end

    // Payload storage is deliberately left unreset; occupancy alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            bufData_q[tailPtr_q] <= bus.fifoDo;
            bufVld_q[tailPtr_q]  <= bus.fifoDoVld;
        end
    end

    overflowCheck: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wrEn && !popEn && (occ_q == OCC_W'(D))));

endmodule
